// File: rtl/op_sequencer.sv
// Command front-end for the 8x8 matrix controller: buffers op words in a FIFO, issues them
// one at a time, streams page data in/out, and inserts a one-cycle gap between operations.
module op_sequencer #(
  parameter int DEPTH      = 8,
  parameter int MM_CYCLES  = 96,
  parameter int XFER_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  input  logic        rd_ready,
  input  logic [31:0] ctl_out_data,
  output logic [31:0] operation,
  output logic [31:0] in_data,
  output logic        ctl_enable,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (MM_CYCLES > XFER_WORDS) ? MM_CYCLES : XFER_WORDS;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] MM_LAST = CW'(MM_CYCLES - 1);
  localparam logic [CW-1:0] XF_LAST = CW'(XFER_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_MM, S_WR, S_RD, S_GAP} state_t;

  state_t         state_q, state_d;
  logic [31:0]    mem_q [DEPTH];
  logic [AW:0]    wptr_q, rptr_q;
  logic [31:0]    op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           empty, full, push, pop, en;
  logic [31:0]    head;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= cmd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    pop      = 1'b0;
    en       = 1'b0;
    wr_ready = 1'b0;
    rd_valid = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        en = 1'b1;
        if (!empty) begin
          pop   = 1'b1;
          op_d  = head;
          cnt_d = '0;
          case (head[3:0])
            4'd0:    state_d = S_GAP;
            4'd1:    state_d = S_MM;
            4'd2:    state_d = S_WR;
            4'd3:    state_d = S_RD;
            default: err_d   = 1'b1;  // illegal word is dropped, never reaches the controller
          endcase
        end
      end
      S_MM: begin
        en = 1'b1;
        if (cnt_q == MM_LAST) state_d = S_GAP;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      S_WR: begin
        wr_ready = 1'b1;
        en       = wr_valid;
        if (wr_valid) begin
          if (cnt_q == XF_LAST) state_d = S_GAP;
          else                  cnt_d   = cnt_q + CW'(1);
        end
      end
      S_RD: begin
        rd_valid = 1'b1;
        en       = rd_ready;
        if (rd_ready) begin
          if (cnt_q == XF_LAST) state_d = S_GAP;
          else                  cnt_d   = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        // operation drops to 0 here so the controller re-arms its opcode edge detector
        en      = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign operation  = (state_q == S_MM || state_q == S_WR || state_q == S_RD) ? op_q : '0;
  assign in_data    = (state_q == S_WR) ? wr_data : '0;
  assign rd_data    = (state_q == S_RD) ? ctl_out_data : '0;
  assign ctl_enable = en && !reset;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign err        = err_q;
endmodule
